// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package pipe_hazard_ctrl_pkg;

   // Register file address width of the 16-bit CPU
   localparam int unsigned REG_AW           = 4;
   // Default bubble count before the pipeline counts as empty (D, E, M, W)
   localparam int unsigned DRAIN_CYCLES_DEF = 4;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in E whose destination is read by the
// instruction in D. Purely combinational so a forwarding unit can reuse it.
module hazard_detect
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] srcAdd1D,
   input  logic [REG_AW-1:0] srcAdd2D,
   input  logic              srcUse1D,
   input  logic              srcUse2D,
   input  logic [REG_AW-1:0] destAddE,
   input  logic              RegWriteE,
   input  logic              MemToRegE,
   output logic              loadUse
);

   // Either live source operand matching the pending load destination
   always_comb begin
      loadUse = MemToRegE & RegWriteE &
                ((srcUse1D & (srcAdd1D == destAddE)) |
                 (srcUse2D & (srcAdd2D == destAddE)));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer with debug-loader drain/halt handshake
// and a saturating stall-cycle counter.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] srcAdd1D,
   input  logic [REG_AW-1:0] srcAdd2D,
   input  logic              srcUse1D,
   input  logic              srcUse2D,
   input  logic [REG_AW-1:0] destAddE,
   input  logic              RegWriteE,
   input  logic              MemToRegE,
   input  logic              branchTakenE,
   input  logic              memBusyM,
   input  logic              haltReq,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              stallM,
   output logic              flushD,
   output logic              flushC,
   output logic              haltAck,
   output logic [CNT_W-1:0]  stallCount
);

   localparam int unsigned   DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

   state_t         state, stateNext;
   logic [DCW-1:0] drainCnt, drainCntNext;
   logic           loadUse;
   logic           sF, sD, sE, sM, fD, fC;

   hazard_detect uHazard (
      .srcAdd1D  (srcAdd1D),
      .srcAdd2D  (srcAdd2D),
      .srcUse1D  (srcUse1D),
      .srcUse2D  (srcUse2D),
      .destAddE  (destAddE),
      .RegWriteE (RegWriteE),
      .MemToRegE (MemToRegE),
      .loadUse   (loadUse)
   );

   // State, drain counter, halt acknowledge and stall counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_RUN;
         drainCnt   <= '0;
         haltAck    <= 1'b0;
         stallCount <= '0;
      end else begin
         state    <= stateNext;
         drainCnt <= drainCntNext;
         haltAck  <= (stateNext == ST_HALTED);
         if (stallF && (stallCount != '1))
            stallCount <= stallCount + 1'b1;
      end
   end

   // Next-state and raw stall/flush priority per state
   always_comb begin
      stateNext    = state;
      drainCntNext = drainCnt;
      sF = 1'b0; sD = 1'b0; sE = 1'b0; sM = 1'b0;
      fD = 1'b0; fC = 1'b0;
      unique case (state)
         ST_RUN: begin
            if (memBusyM) begin
               sF = 1'b1; sD = 1'b1; sE = 1'b1; sM = 1'b1;
            end else if (branchTakenE) begin
               fD = 1'b1; fC = 1'b1;
            end else if (loadUse) begin
               sF = 1'b1; sD = 1'b1; fC = 1'b1;
            end
            if (haltReq && !memBusyM) begin
               stateNext    = ST_DRAIN;
               drainCntNext = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            // A taken branch restarts the bubble count: its target must drain too
            if (memBusyM) begin
               sF = 1'b1; sD = 1'b1; sE = 1'b1; sM = 1'b1;
            end else if (branchTakenE) begin
               fD = 1'b1; fC = 1'b1;
               drainCntNext = DRAIN_LOAD;
            end else begin
               sF = 1'b1; fD = 1'b1;
               if (drainCnt == '0)
                  stateNext = ST_HALTED;
               else
                  drainCntNext = drainCnt - 1'b1;
            end
            if (!haltReq) begin
               stateNext    = ST_RUN;
               drainCntNext = '0;
            end
         end
         ST_HALTED: begin
            sF = 1'b1; sD = 1'b1; fC = 1'b1;
            if (!haltReq)
               stateNext = ST_RUN;
         end
         default: begin
            stateNext    = ST_RUN;
            drainCntNext = '0;
         end
      endcase
   end

   // Controls forced inactive while reset is held low
   always_comb begin
      stallF = sF & reset;
      stallD = sD & reset;
      stallE = sE & reset;
      stallM = sM & reset;
      flushD = fD & reset;
      flushC = fC & reset;
   end

endmodule
